// File: rtl/calc_keypad_ctrl.sv
// Calculator keypad front-end: debounced buttons drive a 4x4 keypad cursor and a three-state arithmetic FSM.
// Optional CALC_DIV_EN turns key (3,3) into a "/" operator with its divider.
module calc_keypad_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 20
) (
    input  logic        clk_in,
    input  logic        sys_rst_n,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_ok,
    output logic [3:0]  cursor_x,
    output logic [3:0]  cursor_y,
    output logic [15:0] input_val,
    output logic [15:0] result,
    output logic [7:0]  op_char,
    output logic        calc_done
);

    localparam int NK = 5;
    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;

    typedef enum logic [1:0] {S_OPA, S_OPB, S_DONE} state_t;

    // Bit order doubles as priority order: ok, up, down, left, right.
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_evt;
    assign key_raw = {key_right, key_left, key_down, key_up, key_ok};

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_d_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk_in) begin
                if (!sys_rst_n) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= key_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        level_reg <= ~level_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign key_evt[gi] = level_reg & ~level_d_reg;
        end
    endgenerate

    state_t      state_reg;
    logic [1:0]  cur_x_reg;
    logic [1:0]  cur_y_reg;
    logic [15:0] input_val_reg;
    logic [15:0] result_reg;
    logic [15:0] operand_a_reg;
    logic [7:0]  op_char_reg;
    logic        calc_done_reg;

    logic        is_digit;
    logic        is_op;
    logic        is_eq;
    logic        is_clr;
    logic [3:0]  digit;
    logic [7:0]  op_code;

    always_comb begin
        is_digit = 1'b0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        is_clr   = 1'b0;
        digit    = 4'd0;
        op_code  = 8'h00;
        case ({cur_y_reg, cur_x_reg})
            4'd0:  begin is_digit = 1'b1; digit = 4'd1; end
            4'd1:  begin is_digit = 1'b1; digit = 4'd2; end
            4'd2:  begin is_digit = 1'b1; digit = 4'd3; end
            4'd3:  begin is_op = 1'b1; op_code = OP_ADD; end
            4'd4:  begin is_digit = 1'b1; digit = 4'd4; end
            4'd5:  begin is_digit = 1'b1; digit = 4'd5; end
            4'd6:  begin is_digit = 1'b1; digit = 4'd6; end
            4'd7:  begin is_op = 1'b1; op_code = OP_SUB; end
            4'd8:  begin is_digit = 1'b1; digit = 4'd7; end
            4'd9:  begin is_digit = 1'b1; digit = 4'd8; end
            4'd10: begin is_digit = 1'b1; digit = 4'd9; end
            4'd11: begin is_op = 1'b1; op_code = OP_MUL; end
            4'd12: is_clr = 1'b1;
            4'd13: begin is_digit = 1'b1; digit = 4'd0; end
            4'd14: is_eq = 1'b1;
`ifdef CALC_DIV_EN
            4'd15: begin is_op = 1'b1; op_code = OP_DIV; end
`endif
            default: ;
        endcase
    end

    // Arithmetic is evaluated at 32 bits so saturation can be detected before truncation.
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] sum32;
    logic [31:0] prod32;
    logic [15:0] calc_val;

    always_comb begin
        a32    = {16'd0, operand_a_reg};
        b32    = {16'd0, input_val_reg};
        sum32  = a32 + b32;
        prod32 = a32 * b32;
        case (op_char_reg)
            OP_ADD:  calc_val = (sum32 > 32'h0000_FFFF) ? 16'hFFFF : sum32[15:0];
            OP_SUB:  calc_val = (operand_a_reg < input_val_reg) ? 16'd0
                                                                : operand_a_reg - input_val_reg;
            OP_MUL:  calc_val = (prod32 > 32'h0000_FFFF) ? 16'hFFFF : prod32[15:0];
`ifdef CALC_DIV_EN
            OP_DIV:  calc_val = (input_val_reg == 16'd0) ? 16'hFFFF
                                                         : operand_a_reg / input_val_reg;
`endif
            default: calc_val = 16'd0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            state_reg     <= S_OPA;
            cur_x_reg     <= 2'd0;
            cur_y_reg     <= 2'd0;
            input_val_reg <= 16'd0;
            result_reg    <= 16'd0;
            operand_a_reg <= 16'd0;
            op_char_reg   <= 8'h00;
            calc_done_reg <= 1'b0;
        end else if (key_evt[0]) begin
            if (is_clr) begin
                state_reg     <= S_OPA;
                input_val_reg <= 16'd0;
                result_reg    <= 16'd0;
                operand_a_reg <= 16'd0;
                op_char_reg   <= 8'h00;
                calc_done_reg <= 1'b0;
            end else if (is_digit) begin
                if (state_reg == S_DONE) begin
                    result_reg    <= 16'd0;
                    op_char_reg   <= 8'h00;
                    calc_done_reg <= 1'b0;
                    input_val_reg <= {12'd0, digit};
                    state_reg     <= S_OPA;
                end else if (input_val_reg < 16'd100) begin
                    input_val_reg <= input_val_reg * 16'd10 + {12'd0, digit};
                end
            end else if (is_op) begin
                case (state_reg)
                    S_OPA: begin
                        operand_a_reg <= input_val_reg;
                        op_char_reg   <= op_code;
                        input_val_reg <= 16'd0;
                        state_reg     <= S_OPB;
                    end
                    S_OPB: op_char_reg <= op_code;
                    default: begin
                        operand_a_reg <= result_reg;
                        op_char_reg   <= op_code;
                        input_val_reg <= 16'd0;
                        calc_done_reg <= 1'b0;
                        state_reg     <= S_OPB;
                    end
                endcase
            end else if (is_eq && state_reg == S_OPB) begin
                result_reg    <= calc_val;
                calc_done_reg <= 1'b1;
                state_reg     <= S_DONE;
            end
        end else if (key_evt[1]) begin
            cur_y_reg <= cur_y_reg - 2'd1;
        end else if (key_evt[2]) begin
            cur_y_reg <= cur_y_reg + 2'd1;
        end else if (key_evt[3]) begin
            cur_x_reg <= cur_x_reg - 2'd1;
        end else if (key_evt[4]) begin
            cur_x_reg <= cur_x_reg + 2'd1;
        end
    end

    assign cursor_x  = {2'b00, cur_x_reg};
    assign cursor_y  = {2'b00, cur_y_reg};
    assign input_val = input_val_reg;
    assign result    = result_reg;
    assign op_char   = op_char_reg;
    assign calc_done = calc_done_reg;

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
// Bench for calc_keypad_ctrl: directed keypad scenarios plus random button traffic against a keypad-level model.
module tb_calc_keypad_ctrl;

    localparam logic [4:0] K_OK    = 5'b00001;
    localparam logic [4:0] K_UP    = 5'b00010;
    localparam logic [4:0] K_DOWN  = 5'b00100;
    localparam logic [4:0] K_LEFT  = 5'b01000;
    localparam logic [4:0] K_RIGHT = 5'b10000;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_ok = 1'b0;
    logic [3:0]  cursor_x, cursor_y;
    logic [15:0] input_val, result;
    logic [7:0]  op_char;
    logic        calc_done;

    int errors = 0;
    int checks = 0;

    // Keypad-level model state.
    string      km;
    int         mx, my, mval, mres, ma, mst;  // mst: 0 entering A, 1 entering B, 2 showing result
    logic [7:0] mop;
    logic       mdone;

    calc_keypad_ctrl #(.DEBOUNCE_CYC(4), .CNT_W(3)) dut (
        .clk_in(clk), .sys_rst_n(sys_rst_n),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_ok(key_ok),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .input_val(input_val),
        .result(result), .op_char(op_char), .calc_done(calc_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cx"},   {28'd0, cursor_x}, mx);
        check({tag, ".cy"},   {28'd0, cursor_y}, my);
        check({tag, ".val"},  {16'd0, input_val}, mval);
        check({tag, ".res"},  {16'd0, result}, mres);
        check({tag, ".op"},   {24'd0, op_char}, {24'd0, mop});
        check({tag, ".done"}, {31'd0, calc_done}, {31'd0, mdone});
        $display("step %-12s cur=(%0d,%0d) val=%0d op=%02h res=%0d done=%0b",
                 tag, cursor_x, cursor_y, input_val, op_char, result, calc_done);
    endtask

    function automatic void model_reset();
        mx = 0; my = 0; mval = 0; mres = 0; ma = 0; mst = 0; mop = 8'h00; mdone = 1'b0;
    endfunction

    function automatic int model_calc();
        longint r;
        case (mop)
            "+": begin r = ma + mval; return (r > 65535) ? 65535 : int'(r); end
            "-": return (ma < mval) ? 0 : ma - mval;
            "*": begin r = longint'(ma) * mval; return (r > 65535) ? 65535 : int'(r); end
            "/": return (mval == 0) ? 65535 : ma / mval;
            default: return 0;
        endcase
    endfunction

    function automatic void model_ok();
        byte ch;
        ch = km[my * 4 + mx];
        if (ch >= "0" && ch <= "9") begin
            if (mst == 2) begin
                mres = 0; mop = 8'h00; mdone = 1'b0; mval = ch - "0"; mst = 0;
            end else if (mval < 100) begin
                mval = mval * 10 + (ch - "0");
            end
        end else if (ch == "+" || ch == "-" || ch == "*" || ch == "/") begin
            if (mst == 0) begin
                ma = mval; mop = ch; mval = 0; mst = 1;
            end else if (mst == 1) begin
                mop = ch;
            end else begin
                ma = mres; mop = ch; mval = 0; mdone = 1'b0; mst = 1;
            end
        end else if (ch == "=") begin
            if (mst == 1) begin
                mres = model_calc(); mdone = 1'b1; mst = 2;
            end
        end else if (ch == "C") begin
            mval = 0; mres = 0; ma = 0; mop = 8'h00; mdone = 1'b0; mst = 0;
        end
    endfunction

    // Only the highest-priority key of a simultaneous press has any effect.
    function automatic void model_event(input logic [4:0] mask);
        if (mask[0])      model_ok();
        else if (mask[1]) my = (my + 3) % 4;
        else if (mask[2]) my = (my + 1) % 4;
        else if (mask[3]) mx = (mx + 3) % 4;
        else if (mask[4]) mx = (mx + 1) % 4;
    endfunction

    task automatic set_keys(input logic [4:0] mask);
        {key_right, key_left, key_down, key_up, key_ok} = mask;
    endtask

    // A press shorter than the debounce length must not register.
    task automatic press(input logic [4:0] mask, input int hold, input string tag);
        set_keys(mask);
        tick(hold);
        set_keys(5'b0);
        tick(12);
        if (hold >= 4) model_event(mask);
        check_all(tag);
    endtask

    task automatic goto_key(input int x, input int y);
        while (mx != x) press(K_RIGHT, 10, "nav");
        while (my != y) press(K_DOWN, 10, "nav");
    endtask

    task automatic enter(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int idx;
            idx = -1;
            for (int k = 0; k < 16; k++) if (km[k] == s[i] && idx < 0) idx = k;
            goto_key(idx % 4, idx / 4);
            press(K_OK, 10, {"key_", s.substr(i, i)});
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
`ifdef CALC_DIV_EN
        km = "123+456-789*C0=/";
`else
        km = "123+456-789*C0=_";
`endif
        model_reset();
        tick(2);
        do_reset();
        tick(1);
        check_all("reset");

        for (int i = 0; i < 4; i++) press(K_RIGHT, 10, "right");
        press(K_UP, 10, "up_wrap");
        check("up_wrap_y", {28'd0, cursor_y}, 3);

        press(K_DOWN, 10, "down_wrap");
        press(K_OK, 3, "glitch_ok");

        // Event latency: raw edge to output update spans sync + debounce + 1 cycles.
        key_ok = 1'b1;
        tick(6);
        check("lat_early", {16'd0, input_val}, 0);
        tick(1);
        check("lat_on_time", {16'd0, input_val}, 1);
        tick(3);
        key_ok = 1'b0;
        tick(12);
        model_event(K_OK);
        check_all("latency");

        enter("C1234");
        check("cap_123", {16'd0, input_val}, 123);
        enter("+45=");
        check("sum_168", {16'd0, result}, 168);
        check("sum_op", {24'd0, op_char}, 32'h2B);

        enter("C999*999=");
        check("mul_sat", {16'd0, result}, 32'hFFFF);
        enter("-5=");
        check("chain_sub", {16'd0, result}, 65530);
        enter("3-7=");
        check("sub_clamp", {16'd0, result}, 0);

        enter("C");
        goto_key(0, 0);
        press(K_OK | K_RIGHT, 10, "simul");
        check("simul_val", {16'd0, input_val}, 1);
        check("simul_cx", {28'd0, cursor_x}, 0);
        enter("C");

`ifdef CALC_DIV_EN
        enter("100/7=");
        check("div_14", {16'd0, result}, 14);
        enter("C5/0=");
        check("div_zero", {16'd0, result}, 32'hFFFF);
        check("div_zero_done", {31'd0, calc_done}, 1);
`else
        enter("12+3");
        goto_key(3, 3);
        press(K_OK, 10, "blank_key");
`endif

        // Reset mid-operation with ok held through reset yields one event afterwards.
        enter("C12+");
        goto_key(0, 0);
        key_ok = 1'b1;
        tick(5);
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(10);
        key_ok = 1'b0;
        tick(12);
        model_reset();
        model_event(K_OK);
        check_all("rst_held");

        for (int n = 0; n < 150; n++) begin
            int k;
            logic [4:0] mask;
            k = $urandom_range(0, 9);
            if (k < 4)      mask = K_OK;
            else if (k < 8) mask = 5'b00001 << (k - 3);
            else            mask = 5'($urandom_range(1, 31));
            press(mask, $urandom_range(2, 9), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
